// File: rtl/imm_decode_stage.sv
// Immediate-decode pipeline stage: classifies a 32-bit RISC-V instruction,
// sign-extends its immediate to XLEN and hands it on through a skid buffer.
module imm_decode_stage #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_illegal
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_CSR = 3'd6;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [6:0]      opc;
    logic            is_i;
    logic            is_s;
    logic            is_b;
    logic            is_j;
    logic            is_u;
    logic            is_csr;
    logic            is_r;
    logic [31:0]     imm32;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;

    logic             in_xfer;
    logic             out_xfer;
    logic             ld_in_main;
    logic             ld_in_skid;
    logic             ld_sk_main;

    logic [31:0]      sk_inst;
    logic [XLEN-1:0]  sk_imm;
    logic [2:0]       sk_fmt;
    logic [TAG_W-1:0] sk_tag;

    assign opc = in_inst[6:0];

    // Opcode classification; the low two bits must be 11 for any match.
    always_comb begin
        is_i   = (opc == 7'h03) || (opc == 7'h13) || (opc == 7'h67);
        is_s   = (opc == 7'h23);
        is_b   = (opc == 7'h63);
        is_j   = (opc == 7'h6F);
        is_u   = (opc == 7'h37) || (opc == 7'h17);
        is_csr = (opc == 7'h73);
        is_r   = (opc == 7'h33) || (opc == 7'h0F);
    end

    // Build a 32-bit immediate, then sign-extend to XLEN in one place.
    always_comb begin
        imm32   = '0;
        dec_fmt = FMT_ILL;
        unique case (1'b1)
            is_i: begin
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
                dec_fmt = FMT_I;
            end
            is_s: begin
                imm32   = {{20{in_inst[31]}}, in_inst[31:25],
                           in_inst[11:7]};
                dec_fmt = FMT_S;
            end
            is_b: begin
                imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7],
                           in_inst[30:25], in_inst[11:8], 1'b0};
                dec_fmt = FMT_B;
            end
            is_j: begin
                imm32   = {{11{in_inst[31]}}, in_inst[31],
                           in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
                dec_fmt = FMT_J;
            end
            is_u: begin
                imm32   = {in_inst[31:12], 12'b0};
                dec_fmt = FMT_U;
            end
            is_csr: begin
                imm32   = {27'b0, in_inst[19:15]};
                dec_fmt = FMT_CSR;
            end
            is_r: begin
                imm32   = '0;
                dec_fmt = FMT_R;
            end
            default: begin
                imm32   = '0;
                dec_fmt = FMT_ILL;
            end
        endcase
        dec_imm = XLEN'($signed(imm32));
    end

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Occupancy state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Occupancy next state; flush overrides any transfer.
    always_comb begin
        state_nx = state;
        if (flush) begin
            state_nx = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_xfer) state_nx = ONE;
                end
                ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_nx = (SKID != 0) ? FULL : ONE;
                    end else if (!in_xfer && out_xfer) begin
                        state_nx = EMPTY;
                    end
                end
                FULL: begin
                    if (out_xfer) state_nx = ONE;
                end
                default: state_nx = EMPTY;
            endcase
        end
    end

    // Per-state outputs and register load strobes.
    always_comb begin
        out_valid  = (state != EMPTY);
        ld_in_main = 1'b0;
        ld_in_skid = 1'b0;
        ld_sk_main = 1'b0;
        if (!flush) begin
            ld_in_main = in_xfer &&
                         ((state == EMPTY) ||
                          ((state == ONE) && out_xfer));
            ld_in_skid = in_xfer && (state == ONE) && !out_xfer
                         && (SKID != 0);
            ld_sk_main = out_xfer && (state == FULL);
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;
            // Ready comes from a flop so upstream sees no out_ready path.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= (state_nx != FULL);
                end
            end
            assign in_ready = rdy_q && !rst;
        end else begin : g_noskid
            assign in_ready = !rst && (!out_valid || out_ready);
        end
    endgenerate

    // Main (output) register: fresh decode or promoted skid entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_inst    <= '0;
            out_imm     <= '0;
            out_fmt     <= '0;
            out_tag     <= '0;
            out_illegal <= 1'b0;
        end else if (ld_in_main) begin
            out_inst    <= in_inst;
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_tag     <= in_tag;
            out_illegal <= (dec_fmt == FMT_ILL);
        end else if (ld_sk_main) begin
            out_inst    <= sk_inst;
            out_imm     <= sk_imm;
            out_fmt     <= sk_fmt;
            out_tag     <= sk_tag;
            out_illegal <= (sk_fmt == FMT_ILL);
        end
    end

    // Skid register catches the entry accepted while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sk_inst <= '0;
            sk_imm  <= '0;
            sk_fmt  <= '0;
            sk_tag  <= '0;
        end else if (ld_in_skid) begin
            sk_inst <= in_inst;
            sk_imm  <= dec_imm;
            sk_fmt  <= dec_fmt;
            sk_tag  <= in_tag;
        end
    end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: XLEN 32/64 skid instances in lockstep
// plus a SKID=0 instance, checked against an arithmetic decode model.
module tb_imm_decode_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_inst;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        rdy32, ov32, ill32;
    logic [31:0] oinst32, oimm32, otag32;
    logic [2:0]  ofmt32;

    logic        rdy64, ov64, ill64;
    logic [31:0] oinst64, otag64;
    logic [63:0] oimm64;
    logic [2:0]  ofmt64;

    logic        flush0, v0, ordy0;
    logic [31:0] inst0, tag0;
    logic        rdy0, ov0, ill0;
    logic [31:0] oinst0, oimm0, otag0;
    logic [2:0]  ofmt0;

    imm_decode_stage #(.XLEN(32), .TAG_W(32), .SKID(1)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy32),
        .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(ov32), .out_ready(out_ready),
        .out_inst(oinst32), .out_imm(oimm32), .out_fmt(ofmt32),
        .out_tag(otag32), .out_illegal(ill32)
    );

    imm_decode_stage #(.XLEN(64), .TAG_W(32), .SKID(1)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(rdy64),
        .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(ov64), .out_ready(out_ready),
        .out_inst(oinst64), .out_imm(oimm64), .out_fmt(ofmt64),
        .out_tag(otag64), .out_illegal(ill64)
    );

    imm_decode_stage #(.XLEN(32), .TAG_W(32), .SKID(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .in_valid(v0), .in_ready(rdy0),
        .in_inst(inst0), .in_tag(tag0),
        .out_valid(ov0), .out_ready(ordy0),
        .out_inst(oinst0), .out_imm(oimm0), .out_fmt(ofmt0),
        .out_tag(otag0), .out_illegal(ill0)
    );

    typedef struct {
        logic [31:0] inst;
        logic [31:0] tag;
    } ent_t;

    ent_t q[$];
    ent_t q0[$];

    function automatic longint sext(longint v, int bits);
        longint span;
        span = longint'(1) << bits;
        return (v >= (span >> 1)) ? v - span : v;
    endfunction

    // Immediate value as a signed number built from weighted fields.
    function automatic void ref_dec(input logic [31:0] i,
                                    output logic [63:0] imm,
                                    output logic [2:0] fmt);
        longint v;
        v   = 0;
        fmt = 3'd7;
        case (i[6:0])
            7'h03, 7'h13, 7'h67: begin
                fmt = 3'd1;
                v = sext(longint'(i[31:20]), 12);
            end
            7'h23: begin
                fmt = 3'd2;
                v = sext(longint'(i[31:25]) * 32 + longint'(i[11:7]), 12);
            end
            7'h63: begin
                fmt = 3'd3;
                v = sext(longint'(i[31]) * 4096 + longint'(i[7]) * 2048
                         + longint'(i[30:25]) * 32
                         + longint'(i[11:8]) * 2, 13);
            end
            7'h6F: begin
                fmt = 3'd5;
                v = sext(longint'(i[31]) * 1048576
                         + longint'(i[19:12]) * 4096
                         + longint'(i[20]) * 2048
                         + longint'(i[30:21]) * 2, 21);
            end
            7'h37, 7'h17: begin
                fmt = 3'd4;
                v = sext(longint'(i[31:12]) * 4096, 32);
            end
            7'h73: begin
                fmt = 3'd6;
                v = longint'(i[19:15]);
            end
            7'h33, 7'h0F: fmt = 3'd0;
            default: ;
        endcase
        imm = v;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = $urandom_range(0, 11);
        case (k)
            0: r[6:0] = 7'h03;
            1: r[6:0] = 7'h13;
            2: r[6:0] = 7'h67;
            3: r[6:0] = 7'h23;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h6F;
            6: r[6:0] = 7'h37;
            7: r[6:0] = 7'h17;
            8: r[6:0] = 7'h73;
            9: r[6:0] = 7'h33;
            10: r[6:0] = 7'h0F;
            default: ;
        endcase
        return r;
    endfunction

    task automatic test_reset();
        #2;
        checks++;
        if (rdy32 !== 1'b0 || rdy64 !== 1'b0 || rdy0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got=%b%b%b exp=000",
                     rdy32, rdy64, rdy0);
        end
        checks++;
        if (ov64 !== 1'b0 || oimm64 !== 64'd0 || oinst64 !== 32'd0 ||
            otag64 !== 32'd0 || ofmt64 !== 3'd0 || ill64 !== 1'b0 ||
            ov32 !== 1'b0 || ov0 !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b imm=%h fmt=%0d exp 0",
                     ov64, oimm64, ofmt64);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy32 !== 1'b1 || rdy64 !== 1'b1 || rdy0 !== 1'b1 ||
            ov64 !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got rdy=%b%b%b v=%b exp=111 0",
                     rdy32, rdy64, rdy0, ov64);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] vi [8];
        logic [63:0] ve [8];
        logic [2:0]  vf [8];
        vi = '{32'hFFF00093, 32'hFE112E23, 32'hFE000EE3, 32'hFF9FF06F,
               32'h800000B7, 32'h000FD073, 32'h00000000, 32'h00B50533};
        ve = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFC,
               64'hFFFFFFFFFFFFFFFC, 64'hFFFFFFFFFFFFFFF8,
               64'hFFFFFFFF80000000, 64'h000000000000001F,
               64'h0, 64'h0};
        vf = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6, 3'd7, 3'd0};
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            in_inst   = vi[k];
            in_tag    = 32'h1000 + k;
            out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (rdy64 !== 1'b1 || ov64 !== 1'b0) begin
                failures++;
                $display("FAIL vec_accept k=%0d got rdy=%b v=%b exp=1 0",
                         k, rdy64, ov64);
            end
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (ov64 !== 1'b1 || oimm64 !== ve[k] || ofmt64 !== vf[k] ||
                ill64 !== (vf[k] == 3'd7) || oinst64 !== vi[k] ||
                otag64 !== 32'h1000 + k) begin
                failures++;
                $display("FAIL vec64 k=%0d got v=%b imm=%h fmt=%0d exp imm=%h fmt=%0d",
                         k, ov64, oimm64, ofmt64, ve[k], vf[k]);
            end
            checks++;
            if (ov32 !== 1'b1 || oimm32 !== ve[k][31:0] ||
                ofmt32 !== vf[k] || ill32 !== (vf[k] == 3'd7)) begin
                failures++;
                $display("FAIL vec32 k=%0d got imm=%h fmt=%0d exp imm=%h fmt=%0d",
                         k, oimm32, ofmt32, ve[k][31:0], vf[k]);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1 out_ready = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (ov64 !== 1'b0) begin
            failures++;
            $display("FAIL vec_drain got v=%b exp=0", ov64);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] a [3];
        a = '{32'h00100093, 32'h00200113, 32'h00300193};
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_inst  = a[k];
            in_tag   = 32'h2000 + k;
            @(negedge clk);
            checks++;
            if (rdy64 !== (k < 2) || rdy32 !== (k < 2)) begin
                failures++;
                $display("FAIL bp_ready k=%0d got=%b exp=%b",
                         k, rdy64, (k < 2));
            end
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (ov64 !== 1'b1 || oinst64 !== a[k] ||
                otag64 !== 32'h2000 + k || oinst32 !== a[k]) begin
                failures++;
                $display("FAIL bp_order k=%0d got v=%b inst=%h exp inst=%h",
                         k, ov64, oinst64, a[k]);
            end
            @(posedge clk);
        end
        @(negedge clk);
        checks++;
        if (ov64 !== 1'b0 || ov32 !== 1'b0) begin
            failures++;
            $display("FAIL bp_nodup got v=%b exp=0", ov64);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_throughput();
        logic [31:0] pinst, ptag;
        logic [63:0] ei;
        logic [2:0]  ef;
        bit have;
        have = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 101; c++) begin
            @(posedge clk);
            #1;
            in_valid = (c < 100);
            in_inst  = gen_inst();
            in_tag   = $urandom;
            @(negedge clk);
            if (c < 100) begin
                checks++;
                if (rdy64 !== 1'b1) begin
                    failures++;
                    $display("FAIL thr_ready c=%0d got=%b exp=1", c, rdy64);
                end
            end
            if (have) begin
                ref_dec(pinst, ei, ef);
                checks++;
                if (ov64 !== 1'b1 || oinst64 !== pinst ||
                    otag64 !== ptag || oimm64 !== ei || ofmt64 !== ef) begin
                    failures++;
                    $display("FAIL thr_data c=%0d got v=%b inst=%h imm=%h exp inst=%h imm=%h",
                             c, ov64, oinst64, oimm64, pinst, ei);
                end
            end
            pinst = in_inst;
            ptag  = in_tag;
            have  = in_valid;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (ov64 !== 1'b0) begin
            failures++;
            $display("FAIL thr_drain got v=%b exp=0", ov64);
        end
    endtask

    task automatic test_random();
        int nout;
        int cyc;
        int sz;
        bit ox, ix, drain;
        ent_t e;
        logic [63:0] ei;
        logic [2:0]  ef;
        nout  = 0;
        cyc   = 0;
        drain = 0;
        q.delete();
        while (!(drain && q.size() == 0) && cyc < 60000) begin
            @(posedge clk);
            #1;
            if (nout >= 10000) drain = 1;
            in_valid  = !drain && ($urandom_range(0, 9) < 7);
            in_inst   = gen_inst();
            in_tag    = $urandom;
            out_ready = drain || ($urandom_range(0, 9) < 7);
            @(negedge clk);
            cyc++;
            sz = q.size();
            checks++;
            if (ov64 !== (sz != 0) || ov32 !== (sz != 0)) begin
                failures++;
                $display("FAIL rnd_valid cyc=%0d got=%b exp=%b",
                         cyc, ov64, (sz != 0));
            end
            checks++;
            if (rdy64 !== (sz < 2) || rdy32 !== (sz < 2)) begin
                failures++;
                $display("FAIL rnd_ready cyc=%0d got=%b exp=%b",
                         cyc, rdy64, (sz < 2));
            end
            if (sz != 0) begin
                e = q[0];
                ref_dec(e.inst, ei, ef);
                checks++;
                if (oinst64 !== e.inst || otag64 !== e.tag ||
                    oimm64 !== ei || ofmt64 !== ef ||
                    ill64 !== (ef == 3'd7) || oimm32 !== ei[31:0] ||
                    ofmt32 !== ef || otag32 !== e.tag) begin
                    failures++;
                    $display("FAIL rnd_data cyc=%0d got inst=%h imm=%h fmt=%0d exp inst=%h imm=%h fmt=%0d",
                             cyc, oinst64, oimm64, ofmt64, e.inst, ei, ef);
                end
            end
            ox = (sz != 0) && out_ready;
            ix = in_valid && (sz < 2);
            if (ox) begin
                void'(q.pop_front());
                nout++;
            end
            if (ix) q.push_back('{in_inst, in_tag});
        end
        checks++;
        if (nout < 10000 || q.size() != 0) begin
            failures++;
            $display("FAIL rnd_budget got outs=%0d left=%0d exp=10000 0",
                     nout, q.size());
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_noskid();
        int nout;
        int cyc;
        int sz;
        ent_t e;
        logic [63:0] ei;
        logic [2:0]  ef;
        nout = 0;
        cyc  = 0;
        q0.delete();
        while (nout < 2000 && cyc < 20000) begin
            @(posedge clk);
            #1;
            v0    = ($urandom_range(0, 9) < 7);
            inst0 = gen_inst();
            tag0  = $urandom;
            ordy0 = ($urandom_range(0, 9) < 6);
            @(negedge clk);
            cyc++;
            sz = q0.size();
            checks++;
            if (ov0 !== (sz != 0) || rdy0 !== (sz == 0 || ordy0)) begin
                failures++;
                $display("FAIL ns_hs cyc=%0d got v=%b rdy=%b exp v=%b rdy=%b",
                         cyc, ov0, rdy0, (sz != 0), (sz == 0 || ordy0));
            end
            if (sz != 0) begin
                e = q0[0];
                ref_dec(e.inst, ei, ef);
                checks++;
                if (oinst0 !== e.inst || otag0 !== e.tag ||
                    oimm0 !== ei[31:0] || ofmt0 !== ef ||
                    ill0 !== (ef == 3'd7)) begin
                    failures++;
                    $display("FAIL ns_data cyc=%0d got inst=%h imm=%h exp inst=%h imm=%h",
                             cyc, oinst0, oimm0, e.inst, ei[31:0]);
                end
                if (ordy0) begin
                    void'(q0.pop_front());
                    nout++;
                end
            end
            if (v0 && (sz == 0 || ordy0)) q0.push_back('{inst0, tag0});
        end
        checks++;
        if (nout < 2000) begin
            failures++;
            $display("FAIL ns_budget got outs=%0d exp=2000", nout);
        end
        @(posedge clk);
        #1;
        v0    = 1'b0;
        ordy0 = 1'b1;
        @(posedge clk);
        #1 ordy0 = 1'b0;
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            in_inst  = 32'h00500293 + (k << 7);
            in_tag   = 32'h3000 + k;
        end
        @(posedge clk);
        #1;
        flush   = 1'b1;
        in_inst = 32'h06400313;
        in_tag  = 32'h3333;
        @(negedge clk);
        checks++;
        if (rdy64 !== 1'b0 || ov64 !== 1'b1) begin
            failures++;
            $display("FAIL flush_full got rdy=%b v=%b exp=0 1", rdy64, ov64);
        end
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ov64 !== 1'b0 || rdy64 !== 1'b1 ||
            ov32 !== 1'b0 || rdy32 !== 1'b1) begin
            failures++;
            $display("FAIL flush_clear got v=%b rdy=%b exp=0 1", ov64, rdy64);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ov64 !== 1'b0) begin
            failures++;
            $display("FAIL flush_drop got v=%b exp=0", ov64);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_inst  = 32'h800000B7;
        in_tag   = 32'hDEAD;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ov64 !== 1'b1 || oimm64 !== 64'hFFFFFFFF80000000) begin
            failures++;
            $display("FAIL arst_pre got v=%b imm=%h exp=1 ffffffff80000000",
                     ov64, oimm64);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ov64 !== 1'b0 || oimm64 !== 64'd0 || oinst64 !== 32'd0 ||
            otag64 !== 32'd0 || ofmt64 !== 3'd0 || ill64 !== 1'b0 ||
            rdy64 !== 1'b0 || ov32 !== 1'b0 || oimm32 !== 32'd0) begin
            failures++;
            $display("FAIL arst_now got v=%b imm=%h tag=%h rdy=%b exp all 0",
                     ov64, oimm64, otag64, rdy64);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy64 !== 1'b1 || ov64 !== 1'b0) begin
            failures++;
            $display("FAIL arst_release got rdy=%b v=%b exp=1 0", rdy64, ov64);
        end
    endtask

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        flush0    = 1'b0;
        v0        = 1'b0;
        inst0     = '0;
        tag0      = '0;
        ordy0     = 1'b0;
        test_reset();
        test_vectors();
        test_backpressure();
        test_throughput();
        test_random();
        test_noskid();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
